// File: rtl/kalman_step_seq.sv
// Sequencer for the six-step Kalman update: captures a sensor sample set,
// walks the per-step ALUs through start/done handshakes and commits the result.
module kalman_step_seq #(
    parameter int NUM_STEPS = 6,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tick,
    input  logic                 gyro_valid,
    input  logic [15:0]          gyro_rate,
    input  logic                 accel_valid,
    input  logic [15:0]          accel_angle,
    output logic [NUM_STEPS-1:0] step_start,
    input  logic [NUM_STEPS-1:0] step_done,
    input  logic [15:0]          res_angle,
    input  logic [15:0]          res_bias,
    output logic [15:0]          alu_angle_in,
    output logic [15:0]          alu_bias_in,
    output logic [15:0]          alu_rate_in,
    output logic [15:0]          alu_meas_in,
    output logic [7:0]           alu_dt_in,
    output logic [15:0]          angle_out,
    output logic [15:0]          bias_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 err
);

    localparam int K_W = $clog2(NUM_STEPS);
    localparam int W_W = $clog2(TIMEOUT);
    localparam logic [K_W-1:0] MEAS_K    = K_W'(3);
    localparam logic [K_W-1:0] LAST_K    = K_W'(NUM_STEPS - 1);
    localparam logic [K_W-1:0] K_ONE     = K_W'(1);
    localparam logic [W_W-1:0] WAIT_LAST = W_W'(TIMEOUT - 1);
    localparam logic [W_W-1:0] W_ONE     = W_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state;
    logic [K_W-1:0] k;
    logic [W_W-1:0] wait_cnt;
    logic [7:0]     dt_cnt;
    logic [7:0]     dt_cap;
    logic [15:0]    acc_reg;
    logic [15:0]    acc_cap;
    logic           acc_fresh;
    logic           meas_en;
    logic [15:0]    rate_cap;
    logic [15:0]    work_angle;
    logic [15:0]    work_bias;
    logic           capture;
    logic [K_W-1:0] next_k;

    assign capture = gyro_valid && (state == IDLE);
    assign next_k  = k + K_ONE;

    // The measurement step is skipped when no fresh accel sample was captured.
    function automatic logic [NUM_STEPS-1:0] start_vec(input logic [K_W-1:0] idx,
                                                       input logic meas);
        logic [NUM_STEPS-1:0] v;
        v = '0;
        if (idx != MEAS_K || meas) v[idx] = 1'b1;
        return v;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            dt_cnt    <= '0;
            dt_cap    <= '0;
            acc_reg   <= '0;
            acc_cap   <= '0;
            acc_fresh <= 1'b0;
            meas_en   <= 1'b0;
            rate_cap  <= '0;
        end else begin
            if (capture) begin
                dt_cap    <= dt_cnt;
                dt_cnt    <= tick ? 8'd1 : 8'd0;
                rate_cap  <= gyro_rate;
                acc_cap   <= accel_valid ? accel_angle : acc_reg;
                meas_en   <= accel_valid | acc_fresh;
                acc_fresh <= 1'b0;
            end else begin
                if (tick && dt_cnt != 8'hFF) dt_cnt <= dt_cnt + 8'd1;
                if (accel_valid) acc_fresh <= 1'b1;
            end
            if (accel_valid) acc_reg <= accel_angle;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state      <= IDLE;
            k          <= '0;
            wait_cnt   <= '0;
            work_angle <= '0;
            work_bias  <= '0;
            angle_out  <= '0;
            bias_out   <= '0;
            step_start <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_start <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            overrun    <= gyro_valid && (state != IDLE);

            // step_start is registered alongside the ISSUE transition so it is high exactly in ISSUE.
            case (state)
                IDLE: begin
                    if (gyro_valid) begin
                        work_angle <= angle_out;
                        work_bias  <= bias_out;
                        k          <= '0;
                        step_start <= start_vec('0, 1'b1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k == MEAS_K && !meas_en) begin
                        k          <= next_k;
                        step_start <= start_vec(next_k, meas_en);
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (step_done[k]) begin
                        work_angle <= res_angle;
                        work_bias  <= res_bias;
                        if (k == LAST_K) begin
                            angle_out <= res_angle;
                            bias_out  <= res_bias;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            k          <= next_k;
                            step_start <= start_vec(next_k, meas_en);
                            state      <= ISSUE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + W_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign alu_angle_in = work_angle;
    assign alu_bias_in  = work_bias;
    assign alu_rate_in  = rate_cap;
    assign alu_meas_in  = acc_cap;
    assign alu_dt_in    = dt_cap;

endmodule

// File: doc/kalman_step_seq.md
Name: kalman_step_seq

Overview:
- Sequencer for the six-step Kalman update datapath: predict, covariance predict, innovation, gain, state update and covariance update.
- Each gyro sample starts one run. The block captures the gyro rate, the latest accel angle and the elapsed dt tick count, then issues one-hot start pulses to each step in turn and waits for its done.
- Angle and bias results are kept in a working copy and committed as the new filter state only when every step completes. It sits between the sensor front end and the per-step ALU blocks.

Parameters:
- NUM_STEPS, 6, number of sequenced datapath steps; index 3 is the measurement (innovation) step.
- TIMEOUT, 64, maximum WAIT cycles per step before the run is aborted.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous reset, active-high (1 = reset).
- tick  in  1  dt time-base tick.
- gyro_valid  in  1  new gyro sample; starts a run.
- gyro_rate  in  16  gyro rate, sign-magnitude.
- accel_valid  in  1  new accel angle sample.
- accel_angle  in  16  accel-derived angle.
- step_start  out  NUM_STEPS  one-hot, one-cycle start pulse to step k.
- step_done  in  NUM_STEPS  done from step k.
- res_angle  in  16  angle result of the active step.
- res_bias  in  16  bias result of the active step.
- alu_angle_in  out  16  working angle.
- alu_bias_in  out  16  working bias.
- alu_rate_in  out  16  captured gyro rate.
- alu_meas_in  out  16  captured accel angle.
- alu_dt_in  out  8  captured dt.
- angle_out  out  16  committed angle.
- bias_out  out  16  committed bias.
- out_valid  out  1  one-cycle pulse: state committed.
- busy  out  1  run in progress.
- overrun  out  1  one-cycle pulse: gyro sample dropped.
- err  out  1  one-cycle pulse: step timeout, run aborted.

Behaviour:
- Reset clears all registers and outputs to 0. The FSM goes to IDLE and the step index to 0. Reset mid-run discards the run immediately.
- dt_cnt (8 bit):
  - +1 on each tick, saturating at 255.
  - On capture, dt_cap <= dt_cnt and dt_cnt <= tick ? 1 : 0.
- Accel register:
  - On accel_valid, acc_reg <= accel_angle and acc_fresh <= 1, in any state.
  - At capture, acc_cap <= acc_reg and meas_en <= acc_fresh, then acc_fresh <= 0.
  - If accel_valid coincides with capture, the new value is captured and counts as fresh; acc_fresh stays 0 afterwards.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, gyro_valid=1: capture gyro_rate, dt, accel; work_angle <= angle_out, work_bias <= bias_out; k <= 0; go to ISSUE.
  - ISSUE, normal step: step_start[k]=1 for exactly this cycle; wait_cnt <= 0; go to WAIT.
  - ISSUE, k==3 with meas_en=0: no pulse, k <= 4, stay in ISSUE. A skip costs 1 cycle.
  - WAIT, step_done[k]=1: work_angle <= res_angle, work_bias <= res_bias. If k == NUM_STEPS-1, commit (angle_out/bias_out <= results), pulse out_valid and go to IDLE. Otherwise k <= k+1 and go to ISSUE.
  - WAIT, no done: wait_cnt += 1. If wait_cnt == TIMEOUT-1, go to IDLE, pulse err, and leave angle_out/bias_out unchanged. A done in that same cycle wins over the timeout.
  - step_done bits other than k are ignored.
- alu_* outputs are driven from the capture and working registers. They are stable for a whole step.
- busy = 1 in ISSUE and WAIT.
- gyro_valid while busy: sample dropped, overrun pulses, capture registers unchanged.
- Latency with every done asserted in its first WAIT cycle, gyro_valid in cycle 0:
  - out_valid in cycle 13 when meas_en=1.
  - out_valid in cycle 12 when the measurement step is skipped.
  - A new gyro_valid is accepted in the out_valid cycle.
- Arithmetic is performed in the step ALUs only. The controller performs no math beyond its counters.

Test Plan:
1. Reset, 5 ticks, accel_valid with 0x1194, then gyro_valid with 0x0064. Each done is returned 1 cycle after its start, results angle=k+1, bias=0x10.
   -> alu_dt_in=5, alu_meas_in=0x1194, out_valid in cycle 13, angle_out=6, bias_out=0x10.
2. Second run with no accel_valid since the last capture.
   -> no step_start[3], out_valid in cycle 12, only 5 start pulses.
3. gyro_valid asserted during cycle 5 of a run.
   -> overrun pulse, alu_rate_in unchanged, a single out_valid.
4. Step 2 done withheld.
   -> err pulses after 64 WAIT cycles, FSM back in IDLE, angle_out/bias_out unchanged, no out_valid.
5. 300 ticks with no gyro_valid, then a run.
   -> alu_dt_in=255. With tick coinciding with capture, the next dt starts from 1.
6. n_rst asserted during WAIT of step 4.
   -> all outputs 0 asynchronously. After release, gyro_valid starts a fresh run from step 0.
